// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the 16-bit data memory.
// It runs one memory operation at a time through IDLE -> ISSUE -> RESP.
module dmem_arbiter #(
  parameter int MEM_SIZE   = 8192,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_valid,
  input  logic        p0_req_write,
  input  logic [15:0] p0_req_addr,
  input  logic [15:0] p0_req_wdata,
  output logic        p0_req_ready,
  output logic        p0_rsp_valid,
  input  logic        p1_req_valid,
  input  logic        p1_req_write,
  input  logic [15:0] p1_req_addr,
  input  logic [15:0] p1_req_wdata,
  output logic        p1_req_ready,
  output logic        p1_rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [15:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // A 17-bit limit lets MEM_SIZE reach 65536 without wrapping the compare.
  localparam logic [16:0] MEM_LIMIT = 17'(MEM_SIZE);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        port_q, port_d;
  logic        err_q, err_d;
  logic        last_grant_q, last_grant_d;

  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [1:0]  grant;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        sel;
  logic        in_idle;
  logic        in_issue;
  logic        in_resp;

  assign req_valid    = {p1_req_valid, p0_req_valid};
  assign req_write    = {p1_req_write, p0_req_write};
  assign req_addr[0]  = p0_req_addr;
  assign req_addr[1]  = p1_req_addr;
  assign req_wdata[0] = p0_req_wdata;
  assign req_wdata[1] = p1_req_wdata;

  assign in_idle  = (state_q == IDLE);
  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  // A contested cycle goes to port 0 under fixed priority, otherwise to the port not served last.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      if (FIXED_PRIO || last_grant_q) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end
  end

  assign sel = grant[1];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    port_d       = port_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d      = ISSUE;
          addr_d       = req_addr[sel];
          wdata_d      = req_wdata[sel];
          write_d      = req_write[sel];
          port_d       = sel;
          err_d        = ({1'b0, req_addr[sel]} >= MEM_LIMIT);
          last_grant_d = sel;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      port_q       <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      port_q       <= port_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready[gi] = in_idle & grant[gi];
    assign rsp_valid[gi] = in_resp & (port_q == 1'(gi));
  end

  assign p0_req_ready = req_ready[0];
  assign p1_req_ready = req_ready[1];
  assign p0_rsp_valid = rsp_valid[0];
  assign p1_rsp_valid = rsp_valid[1];

  // Strobes decode from the state register, so an asynchronous reset drops them immediately.
  assign mem_address = addr_q;
  assign mem_data    = wdata_q;
  assign mem_write   = in_issue & write_q & ~err_q;
  assign mem_read    = in_issue & ~write_q & ~err_q;

  assign rsp_rdata = (in_resp & ~write_q & ~err_q) ? mem_read_data : 16'h0000;
  assign rsp_err   = in_resp & err_q;
  assign busy      = ~in_idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a scoreboard of expected responses filled at accept, plus a dmem model.
// A second fixed-priority instance shares the request inputs so that arbitration order can be checked.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_valid = 1'b0, p0_write = 1'b0;
  logic [15:0] p0_addr = '0, p0_wdata = '0;
  logic        p1_valid = 1'b0, p1_write = 1'b0;
  logic [15:0] p1_addr = '0, p1_wdata = '0;
  logic        p0_ready, p1_ready, p0_rsp, p1_rsp;
  logic [15:0] rsp_rdata, mem_address, mem_data;
  logic [15:0] mem_rdata = '0;
  logic        rsp_err, mem_write, mem_read, busy;
  logic        f_p0_ready, f_p1_ready, f_p0_rsp, f_p1_rsp, f_rsp_err;
  logic        f_mem_write, f_mem_read, f_busy;
  logic [15:0] f_rsp_rdata, f_mem_address, f_mem_data;
  logic [15:0] f_mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_SIZE(8192), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_valid), .p0_req_write(p0_write), .p0_req_addr(p0_addr),
    .p0_req_wdata(p0_wdata), .p0_req_ready(p0_ready), .p0_rsp_valid(p0_rsp),
    .p1_req_valid(p1_valid), .p1_req_write(p1_write), .p1_req_addr(p1_addr),
    .p1_req_wdata(p1_wdata), .p1_req_ready(p1_ready), .p1_rsp_valid(p1_rsp),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_address(mem_address),
    .mem_data(mem_data), .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.MEM_SIZE(8192), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_valid), .p0_req_write(p0_write), .p0_req_addr(p0_addr),
    .p0_req_wdata(p0_wdata), .p0_req_ready(f_p0_ready), .p0_rsp_valid(f_p0_rsp),
    .p1_req_valid(p1_valid), .p1_req_write(p1_write), .p1_req_addr(p1_addr),
    .p1_req_wdata(p1_wdata), .p1_req_ready(f_p1_ready), .p1_rsp_valid(f_p1_rsp),
    .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err), .mem_address(f_mem_address),
    .mem_data(f_mem_data), .mem_write(f_mem_write), .mem_read(f_mem_read),
    .mem_read_data(f_mem_rdata), .busy(f_busy)
  );

  typedef struct {
    logic        port;
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          acc_port[$];
  int          acc_cyc[$];
  int          f_acc[$];
  logic [15:0] dmem    [0:8191];
  logic [15:0] ref_mem [0:8191];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // dmem model: write on the strobe edge, read data registered one cycle after the read edge
  always @(posedge clk) begin
    if (mem_write) dmem[mem_address[12:0]] <= mem_data;
    if (mem_read) mem_rdata <= dmem[mem_address[12:0]];
  end

  function automatic exp_t make_exp(input logic port, input logic w,
                                    input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.port  = port;
    e.write = w;
    e.addr  = a;
    e.wdata = d;
    e.err   = (a >= 16'd8192);
    e.rdata = (!w && !e.err) ? ref_mem[a[12:0]] : 16'h0000;
    e.cyc   = cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      check_val("strobe_excl", {31'b0, mem_write & mem_read}, 0);
      check_val("ready_busy", {31'b0, (p0_ready | p1_ready) & busy}, 0);
      check_val("rsp_single", {31'b0, p0_rsp & p1_rsp}, 0);
      if (p0_rsp | p1_rsp) begin
        if (sb.size() == 0) begin
          check_val("spurious_rsp", {31'b0, p1_rsp}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("rsp  port=%0d rdata=%h err=%0b", p1_rsp, rsp_rdata, rsp_err);
          check_val("rsp_port", {31'b0, p1_rsp}, {31'b0, e.port});
          check_val("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, e.rdata});
          check_val("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          check_val("rsp_latency", cyc - e.cyc, 2);
          if (e.write && !e.err) ref_mem[e.addr[12:0]] = e.wdata;
        end
      end else begin
        check_val("rdata_quiet", {15'b0, rsp_err, rsp_rdata}, 0);
      end
      if (p0_valid & p0_ready) begin
        $display("acc  port=0 write=%0b addr=%h wdata=%h", p0_write, p0_addr, p0_wdata);
        sb.push_back(make_exp(1'b0, p0_write, p0_addr, p0_wdata));
        acc_port.push_back(0);
        acc_cyc.push_back(cyc);
      end
      if (p1_valid & p1_ready) begin
        $display("acc  port=1 write=%0b addr=%h wdata=%h", p1_write, p1_addr, p1_wdata);
        sb.push_back(make_exp(1'b1, p1_write, p1_addr, p1_wdata));
        acc_port.push_back(1);
        acc_cyc.push_back(cyc);
      end
      if (p0_valid & f_p0_ready) f_acc.push_back(0);
      if (p1_valid & f_p1_ready) f_acc.push_back(1);
    end
  end

  task automatic req(input int port, input logic w, input logic [15:0] a, input logic [15:0] d);
    bit ok;
    @(posedge clk); #1;
    if (port == 0) begin
      p0_valid = 1'b1; p0_write = w; p0_addr = a; p0_wdata = d;
    end else begin
      p1_valid = 1'b1; p1_write = w; p1_addr = a; p1_wdata = d;
    end
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_ready : p1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("accept_timeout", 0, 1);
    @(posedge clk); #1;
    p0_valid = 1'b0;
    p1_valid = 1'b0;
  endtask

  initial begin
    int n_rr;
    int n_fp;
    bit ok;
    for (int i = 0; i < 8192; i++) begin
      dmem[i]    = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    #12;
    check_val("rst_busy", {31'b0, busy}, 0);
    check_val("rst_ready", {30'b0, p1_ready, p0_ready}, 0);
    check_val("rst_rsp", {30'b0, p1_rsp, p0_rsp}, 0);
    check_val("rst_strobes", {30'b0, mem_write, mem_read}, 0);
    check_val("rst_addr_data", {mem_address, mem_data}, 0);
    check_val("rst_rdata_err", {15'b0, rsp_err, rsp_rdata}, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // write then read back through port 0
    req(0, 1'b1, 16'h0010, 16'hBEEF);
    check_val("wr_strobe", {30'b0, mem_write, mem_read}, 32'h2);
    check_val("wr_addr", {16'b0, mem_address}, 32'h0010);
    check_val("wr_data", {16'b0, mem_data}, 32'hBEEF);
    repeat (2) @(posedge clk);
    req(0, 1'b0, 16'h0010, 16'h0000);
    check_val("rd_strobe", {30'b0, mem_write, mem_read}, 32'h1);
    repeat (2) @(posedge clk);

    // address range boundary on port 1
    req(1, 1'b0, 16'h2000, 16'h0000);
    check_val("oor_strobe", {30'b0, mem_write, mem_read}, 0);
    repeat (2) @(posedge clk);
    req(1, 1'b1, 16'h1FFF, 16'hA5A5);
    check_val("top_wr_strobe", {30'b0, mem_write, mem_read}, 32'h2);
    check_val("top_wr_addr", {16'b0, mem_address}, 32'h1FFF);
    repeat (2) @(posedge clk);
    req(1, 1'b0, 16'h1FFF, 16'h0000);
    check_val("top_rd_strobe", {30'b0, mem_write, mem_read}, 32'h1);
    repeat (2) @(posedge clk);
    req(1, 1'b1, 16'hFFFF, 16'h5555);
    check_val("oor_wr_strobe", {30'b0, mem_write, mem_read}, 0);
    repeat (3) @(posedge clk);

    // both ports continuously valid: round-robin alternates, fixed priority keeps port 0
    acc_port.delete();
    acc_cyc.delete();
    f_acc.delete();
    @(posedge clk); #1;
    p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 16'h0010; p0_wdata = 16'h0;
    p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 16'h1FFF; p1_wdata = 16'h0;
    repeat (14) @(posedge clk);
    #1;
    n_rr = acc_port.size();
    n_fp = f_acc.size();
    check_val("rr_count_ge4", {31'b0, n_rr >= 4}, 1);
    if (n_rr > 0) check_val("rr_first", acc_port[0], 0);
    for (int i = 1; i < n_rr; i++) begin
      check_val("rr_alternate", acc_port[i], 1 - acc_port[i-1]);
      check_val("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    end
    check_val("fp_count_ge3", {31'b0, n_fp >= 3}, 1);
    for (int i = 0; i < n_fp; i++) check_val("fp_p0_only", f_acc[i], 0);
    p0_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (f_acc.size() > n_fp) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("fp_p1_after_drop_seen", {31'b0, ok}, 1);
    if (ok) check_val("fp_p1_after_drop", f_acc[n_fp], 1);
    @(posedge clk); #1;
    p1_valid = 1'b0;
    repeat (5) @(posedge clk);

    // reset during the ISSUE cycle of a write suppresses it and its response
    req(0, 1'b1, 16'h0005, 16'h1234);
    check_val("mid_wr_strobe", {31'b0, mem_write}, 1);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_strobe", {30'b0, mem_write, mem_read}, 0);
    check_val("mid_rst_busy", {31'b0, busy}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    req(0, 1'b0, 16'h0005, 16'h0000);
    repeat (2) @(posedge clk);

    // first contested round after reset goes to port 0
    acc_port.delete();
    acc_cyc.delete();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 16'h0010;
    p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 16'h0005;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (acc_port.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("post_rst_accept_seen", {31'b0, ok}, 1);
    if (ok) check_val("post_rst_first", acc_port[0], 0);
    @(posedge clk); #1;
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    repeat (6) @(posedge clk);
    check_val("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
